// File: rtl/updown_cmd_sequencer.sv
// ============================================================================
// updown_cmd_sequencer
// ----------------------------------------------------------------------------
// Shares a single up/down counter between two requesters (A and B). Each
// requester presents a {dir, len} command over a valid/ready handshake. A
// round-robin arbiter grants one command at a time. The sequencer then drives
// the counter's up/down enables for len cycles and keeps a shadow copy of the
// counter value in count.
//
// Optional feature (compile-time macro UDC_SAT_EN):
//   Steps that would leave [LIMIT_LO, LIMIT_HI] are not issued. The command
//   ends early and reports sat_hit. When the macro is undefined, count wraps
//   modulo 2^CW and sat_hit is always 0.
//
// Parameters:
//   CW        counter / shadow width
//   LW        command length width
//   LIMIT_HI  upper count limit (saturating build only)
//   LIMIT_LO  lower count limit (saturating build only)
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   a_valid/a_ready/a_dir/a_len requester A command handshake and fields
//   b_valid/b_ready/b_dir/b_len requester B command handshake and fields
//   up, down                   registered counter enables
//   count                      shadow counter value
//   busy                       high while a command is running or completing
//   done                       one-cycle completion pulse
//   done_id                    owner of the completed command (0 = A, 1 = B)
//   sat_hit                    completed command was cut short by a limit
// ============================================================================
module updown_cmd_sequencer #(
    parameter int CW       = 8,
    parameter int LW       = 8,
    parameter int LIMIT_HI = 255,
    parameter int LIMIT_LO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_dir,
    input  logic [LW-1:0] a_len,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_dir,
    input  logic [LW-1:0] b_len,
    output logic          up,
    output logic          down,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic          sat_hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic          prio_b;      // 1: B holds round-robin priority
    logic          owner;       // requester of the command in flight
    logic          dir_r;       // direction of the command in flight
    logic [LW-1:0] remaining;   // steps still to issue after the current one
    logic          sat_r;

    logic          grant_a;
    logic          grant_b;
    logic          accept;
    logic          acc_dir;
    logic [LW-1:0] acc_len;
    logic          blk_acc;     // first step of the incoming command is blocked
    logic          blk_run;     // next step of the running command is blocked

    // Limits must describe a non-empty range representable in CW bits.
    if (LIMIT_LO > LIMIT_HI) begin : g_bad_limit_order
        $error("updown_cmd_sequencer: LIMIT_LO must not exceed LIMIT_HI");
    end
    if (LIMIT_HI >= (2 ** CW)) begin : g_bad_limit_width
        $error("updown_cmd_sequencer: LIMIT_HI does not fit in CW bits");
    end

    function automatic logic [CW-1:0] step_count(input logic [CW-1:0] c,
                                                 input logic          d);
        return d ? c + 1'b1 : c - 1'b1;
    endfunction

`ifdef UDC_SAT_EN
    localparam logic [CW-1:0] HI_C = LIMIT_HI[CW-1:0];
    localparam logic [CW-1:0] LO_C = LIMIT_LO[CW-1:0];

    // A step is blocked when count already sits on the limit it moves toward.
    function automatic logic step_blocked(input logic [CW-1:0] c,
                                          input logic          d);
        return d ? (c >= HI_C) : (c <= LO_C);
    endfunction

    assign blk_acc = step_blocked(count, acc_dir);
    assign blk_run = step_blocked(count, dir_r);
`else
    assign blk_acc = 1'b0;
    assign blk_run = 1'b0;
`endif

    // Arbitration: a lone valid requester wins; on contention the priority
    // holder wins. Ready is only offered in IDLE and never while in reset.
    assign grant_a = (state == IDLE) && a_valid && (!b_valid || !prio_b);
    assign grant_b = (state == IDLE) && b_valid && (!a_valid ||  prio_b);
    assign a_ready = rst_n && grant_a;
    assign b_ready = rst_n && grant_b;
    assign accept  = a_ready || b_ready;
    assign acc_dir = grant_b ? b_dir : a_dir;
    assign acc_len = grant_b ? b_len : a_len;

    assign busy    = (state != IDLE);
    assign done_id = owner;
    assign sat_hit = sat_r;

    // Direction is pure command data; it is only meaningful while a command
    // is in flight, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            dir_r <= acc_dir;
        end
    end

    // The first step is issued on the accept edge so the pulse and the count
    // update appear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio_b    <= 1'b0;
            owner     <= 1'b0;
            remaining <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
            sat_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prio_b <= grant_a;
                        owner  <= grant_b;
                        if (acc_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (blk_acc) begin
                            state <= DONE;
                            done  <= 1'b1;
                            sat_r <= 1'b1;
                        end else begin
                            state     <= RUN;
                            up        <= acc_dir;
                            down      <= ~acc_dir;
                            count     <= step_count(count, acc_dir);
                            remaining <= acc_len - 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (remaining == '0) begin
                        state <= DONE;
                        up    <= 1'b0;
                        down  <= 1'b0;
                        done  <= 1'b1;
                    end else if (blk_run) begin
                        state <= DONE;
                        up    <= 1'b0;
                        down  <= 1'b0;
                        done  <= 1'b1;
                        sat_r <= 1'b1;
                    end else begin
                        up        <= dir_r;
                        down      <= ~dir_r;
                        count     <= step_count(count, dir_r);
                        remaining <= remaining - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    sat_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    up    <= 1'b0;
                    down  <= 1'b0;
                    done  <= 1'b0;
                    sat_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_cmd_sequencer.sv
// ============================================================================
// tb_updown_cmd_sequencer
// ----------------------------------------------------------------------------
// Directed bench for updown_cmd_sequencer with hand-computed expectations.
// Expectations that depend on the UDC_SAT_EN build are selected below.
// ============================================================================
module tb_updown_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_dir, b_valid, b_dir;
    logic [7:0] a_len, b_len;
    logic       a_ready, b_ready;
    logic       up, down, busy, done, done_id, sat_hit;
    logic [7:0] count;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int up_cnt   = 0;
    int dn_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ovl_cnt  = 0;
    int stray    = 0;
    logic done_id_s = 1'b0;
    logic sat_s     = 1'b0;
    int grant_q[$];

`ifdef UDC_SAT_EN
    // 5 down 7 stops at 0; three +1 steps from 0; then limit tests at 255.
    localparam int T2_STEPS = 5, T2_CNT = 0,   T2_SAT = 1;
    localparam int T3_CNT   = 3;
    localparam int T6_STEPS = 0, T6_CNT = 0,   T6_SAT = 1;
`else
    // 5-7 wraps to 254; 254+3 wraps to 1; 0-2 wraps to 254.
    localparam int T2_STEPS = 7, T2_CNT = 254, T2_SAT = 0;
    localparam int T3_CNT   = 1;
    localparam int T6_STEPS = 2, T6_CNT = 254, T6_SAT = 0;
`endif

    updown_cmd_sequencer #(
        .CW(8), .LW(8), .LIMIT_HI(255), .LIMIT_LO(0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_dir   (a_dir),
        .a_len   (a_len),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_dir   (b_dir),
        .b_len   (b_len),
        .up      (up),
        .down    (down),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sat_hit (sat_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle.
    always @(negedge clk) begin
        if (up)   up_cnt++;
        if (down) dn_cnt++;
        if (up && down) ovl_cnt++;
        if ((up || down) && !busy) stray++;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_id_s = done_id;
            sat_s     = sat_hit;
        end
        if (a_valid && a_ready) grant_q.push_back(0);
        if (b_valid && b_ready) grant_q.push_back(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command from requester id, wait for completion, and check
    // pulses, latency (accept edge to done cycle), owner, sat flag and count.
    task automatic do_cmd(input string tag, input bit id, input bit dir,
                          input int len, input int exp_steps,
                          input int exp_count, input int exp_sat);
        int up0, dn0, dc0, t_acc, waited;
        logic rdy;
        up0 = up_cnt;
        dn0 = dn_cnt;
        dc0 = done_cnt;
        @(posedge clk); #1;
        if (id) begin
            b_valid = 1'b1; b_dir = dir; b_len = len[7:0];
        end else begin
            a_valid = 1'b1; a_dir = dir; a_len = len[7:0];
        end
        #1;
        waited = 0;
        rdy = id ? b_ready : a_ready;
        while (!rdy && waited < 20) begin
            @(posedge clk); #2;
            waited++;
            rdy = id ? b_ready : a_ready;
        end
        check({tag, "_ready"}, int'(rdy), 1);
        @(posedge clk); #1;
        t_acc   = cyc;
        a_valid = 1'b0;
        b_valid = 1'b0;
        waited  = 0;
        while (done_cnt == dc0 && waited < 600) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_done"},    done_cnt - dc0, 1);
        check({tag, "_latency"}, done_cyc - t_acc, exp_steps);
        check({tag, "_up"},      up_cnt - up0, dir ? exp_steps : 0);
        check({tag, "_down"},    dn_cnt - dn0, dir ? 0 : exp_steps);
        check({tag, "_id"},      int'(done_id_s), int'(id));
        check({tag, "_sat"},     int'(sat_s), exp_sat);
        check({tag, "_count"},   int'(count), exp_count);
    endtask

    initial begin
        int dc0, up0, waited;
        logic rdy;

        // Reset with A already asserting valid: nothing may be offered.
        rst_n   = 1'b0;
        a_valid = 1'b1; a_dir = 1'b1; a_len = 8'd3;
        b_valid = 1'b0; b_dir = 1'b0; b_len = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_up",      int'(up), 0);
        check("rst_down",    int'(down), 0);
        check("rst_count",   int'(count), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_done",    int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_sat",     int'(sat_hit), 0);
        check("rst_a_ready", int'(a_ready), 0);
        check("rst_b_ready", int'(b_ready), 0);
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // A: up 5 from 0.
        do_cmd("t1", 1'b0, 1'b1, 5, 5, 5, 0);
        // B: down 7 from 5.
        do_cmd("t2", 1'b1, 1'b0, 7, T2_STEPS, T2_CNT, T2_SAT);

        // Both valid, priority back on A: grants must alternate A,B,A.
        grant_q.delete();
        dc0 = done_cnt;
        up0 = up_cnt;
        @(posedge clk); #1;
        a_valid = 1'b1; a_dir = 1'b1; a_len = 8'd1;
        b_valid = 1'b1; b_dir = 1'b1; b_len = 8'd1;
        waited = 0;
        while (grant_q.size() < 3 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        waited  = 0;
        while (done_cnt - dc0 < 3 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        check("t3_grants", grant_q.size(), 3);
        check("t3_grant0", grant_q.size() > 0 ? grant_q[0] : 9, 0);
        check("t3_grant1", grant_q.size() > 1 ? grant_q[1] : 9, 1);
        check("t3_grant2", grant_q.size() > 2 ? grant_q[2] : 9, 0);
        check("t3_dones",  done_cnt - dc0, 3);
        check("t3_ups",    up_cnt - up0, 3);
        check("t3_count",  int'(count), T3_CNT);

        // Zero-length command: accepted, no pulses, done right after accept.
        do_cmd("t4", 1'b0, 1'b1, 0, 0, T3_CNT, 0);

`ifdef UDC_SAT_EN
        // Climb to 253, then hit the upper limit mid-command and at start.
        do_cmd("t5a", 1'b0, 1'b1, 250, 250, 253, 0);
        do_cmd("t5b", 1'b1, 1'b1, 5, 2, 255, 1);
        do_cmd("t5c", 1'b0, 1'b1, 3, 0, 255, 1);
`endif

        // Reset in the third RUN cycle of a B down command.
        @(posedge clk); #1;
        b_valid = 1'b1; b_dir = 1'b0; b_len = 8'd10;
        #1;
        waited = 0;
        rdy = b_ready;
        while (!rdy && waited < 20) begin
            @(posedge clk); #2;
            waited++;
            rdy = b_ready;
        end
        check("t6_ready", int'(rdy), 1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("t6_run_down", int'(down), 1);
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_rst_up",    int'(up), 0);
        check("t6_rst_down",  int'(down), 0);
        check("t6_rst_busy",  int'(busy), 0);
        check("t6_rst_count", int'(count), 0);
        check("t6_rst_done",  int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - dc0, 0);
        do_cmd("t6_after", 1'b0, 1'b0, 2, T6_STEPS, T6_CNT, T6_SAT);

        check("overlap_up_down", ovl_cnt, 0);
        check("pulse_outside_run", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
